// File: rtl/dot_product_issuer.sv
// -----------------------------------------------------------------------------
// dot_product_issuer
//   Initiator-side front end for a multi-cycle dot-product unit. Collects a
//   serial element stream into two operand vectors (first VECTOR_SIZE elements
//   into dp_vec1, next VECTOR_SIZE into dp_vec2), pulses dp_start once, waits
//   for dp_valid (bounded by TIMEOUT_CYCLES) and presents the result on a
//   valid/ready output stream.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data  operand element stream
//   dp_vec1/dp_vec2            registered operand vectors to the unit
//   dp_start                   one-cycle launch pulse
//   dp_valid/dp_result         unit result, only looked at while waiting
//   res_valid/res_ready        result handshake
//   res_data/res_error         result, error=1 means timeout with data 0
//   busy                       low only when idle in LOAD_A with idx 0
// -----------------------------------------------------------------------------

// One operand lane: holds element i of each vector.
module dot_product_issuer_lane #(
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_a,
  input  logic                  wr_b,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] vec1,
  output logic [DATA_WIDTH-1:0] vec2
);
  logic [DATA_WIDTH-1:0] vec1_q, vec1_d;
  logic [DATA_WIDTH-1:0] vec2_q, vec2_d;

  always_comb begin
    vec1_d = vec1_q;
    vec2_d = vec2_q;
    if (wr_a) vec1_d = din;
    if (wr_b) vec2_d = din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec1_q <= '0;
      vec2_q <= '0;
    end else begin
      vec1_q <= vec1_d;
      vec2_q <= vec2_d;
    end
  end

  assign vec1 = vec1_q;
  assign vec2 = vec2_q;
endmodule

module dot_product_issuer #(
  parameter int VECTOR_SIZE    = 4,
  parameter int DATA_WIDTH     = 31,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] dp_vec1 [VECTOR_SIZE],
  output logic [DATA_WIDTH-1:0] dp_vec2 [VECTOR_SIZE],
  output logic                  dp_start,
  input  logic                  dp_valid,
  input  logic [DATA_WIDTH-1:0] dp_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_error,
  output logic                  busy
);
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_SIZE - 1);
  // Give up in the WAIT cycle where the incremented timer reaches
  // TIMEOUT_CYCLES-1, so res_valid rises TIMEOUT_CYCLES cycles after dp_start.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT,
    OUTPUT
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_error_q, res_error_d;

  logic                  loading;
  logic                  accept;
  logic                  last_elem;

  // Reset gates in_ready so nothing looks accepted while held in reset.
  assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_ready  = reset && loading;
  assign accept    = in_valid && in_ready;
  assign last_elem = (idx_q == IDX_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    case (state_q)
      LOAD_A, LOAD_B: begin
        if (accept) begin
          if (last_elem) begin
            idx_d   = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A result arriving on the timeout cycle takes priority.
        if (dp_valid) begin
          res_data_d  = dp_result;
          res_error_d = 1'b0;
          state_d     = OUTPUT;
        end else if (timer_q == TMR_LAST) begin
          res_data_d  = '0;
          res_error_d = 1'b1;
          state_d     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (res_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      timer_q     <= '0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  // Operand lanes: lane g captures the element accepted while idx == g.
  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_lane
    logic hit;
    assign hit = accept && (idx_q == IDX_W'(g));
    dot_product_issuer_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr_a (hit && (state_q == LOAD_A)),
      .wr_b (hit && (state_q == LOAD_B)),
      .din  (in_data),
      .vec1 (dp_vec1[g]),
      .vec2 (dp_vec2[g])
    );
  end

  assign dp_start  = (state_q == ISSUE);
  assign res_valid = (state_q == OUTPUT);
  assign res_data  = res_data_q;
  assign res_error = res_error_q;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));
endmodule
